// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order store queue between the core's store path and a data-memory port.
// Each store is turned into a word-aligned write with byte strobes and
// lane-replicated data. Entries leave the queue strictly in acceptance order,
// one per dm_ack.
//
// Optional feature (compile-time macro): STORE_MISALIGN_CHK_EN
//   When defined, a misaligned SH or SW is accepted but not enqueued, and the
//   misalign output pulses for one cycle. When undefined, the misalign port
//   does not exist, and the low address bits that SH/SW do not use are ignored.
//
// Parameters
//   DEPTH     number of queue entries (a power of 2, at least 2)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   st_valid  store request present
//   st_addr   store byte address
//   st_data   raw rs2 value
//   funct3    000 SB, 001 SH, 010 SW; other codes are accepted and dropped
//   st_ready  queue can take a request (registered occupancy < DEPTH)
//   dm_req    head entry is being presented to memory
//   dm_addr   word-aligned head address ([1:0] = 00)
//   dm_wdata  lane-replicated head data
//   dm_wstrb  head byte enables (bit i covers dm_wdata[8i+7:8i])
//   misalign  one-cycle misaligned-store pulse (macro builds only)
//   dm_ack    memory accepted the current request
//   sb_empty  queue holds no entries
//   sb_count  current occupancy
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [2:0]             funct3,
  output logic                   st_ready,
  output logic                   dm_req,
  output logic [31:0]            dm_addr,
  output logic [31:0]            dm_wdata,
  output logic [3:0]             dm_wstrb,
`ifdef STORE_MISALIGN_CHK_EN
  output logic                   misalign,
`endif
  input  logic                   dm_ack,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Only the word address is stored; the low two bits are always 00 on issue.
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          op_ok;
  logic          mis_det;
  logic [3:0]    new_strb;
  logic [31:0]   new_data;
  logic          accept;
  logic          push;
  logic          pop;
  logic          misalign_q, misalign_d;

  // ---------------------------------------------------------------------------
  // Request decode: strobes and lane replication per store width
  // ---------------------------------------------------------------------------
  always_comb begin
    op_ok    = 1'b1;
    new_strb = 4'b0000;
    new_data = 32'h0;
    case (funct3)
      3'b000: begin
        new_strb = 4'b0001 << st_addr[1:0];
        new_data = {4{st_data[7:0]}};
      end
      3'b001: begin
        new_strb = st_addr[1] ? 4'b1100 : 4'b0011;
        new_data = {2{st_data[15:0]}};
      end
      3'b010: begin
        new_strb = 4'b1111;
        new_data = st_data;
      end
      default: begin
        op_ok = 1'b0;
      end
    endcase
  end

`ifdef STORE_MISALIGN_CHK_EN
  always_comb begin
    mis_det = 1'b0;
    if ((funct3 == 3'b001) && st_addr[0]) begin
      mis_det = 1'b1;
    end else if ((funct3 == 3'b010) && (st_addr[1:0] != 2'b00)) begin
      mis_det = 1'b1;
    end
  end
`else
  assign mis_det = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes. st_ready comes only from registered occupancy, so a full queue
  // stays closed in the cycle it is being drained; the slot reopens next edge.
  // ---------------------------------------------------------------------------
  assign st_ready = (count_q < DEPTH_C);
  assign accept   = st_valid && st_ready;
  assign push     = accept && op_ok && !mis_det;
  assign pop      = (count_q != '0) && dm_ack;

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next state. DEPTH is a power of 2, so the pointers
  // wrap by natural overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign misalign_d = accept && mis_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage; cleared on reset so nothing stale can ever be presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr_q] <= st_addr[31:2];
      data_q[wr_ptr_q] <= new_data;
      strb_q[wr_ptr_q] <= new_strb;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. No bypass: the head is always a registered entry, and the memory
  // side is forced to zero while the queue is empty.
  // ---------------------------------------------------------------------------
  assign sb_count = count_q;
  assign sb_empty = (count_q == '0);
  assign dm_req   = !sb_empty;
  assign dm_addr  = dm_req ? {addr_q[rd_ptr_q], 2'b00} : 32'h0;
  assign dm_wdata = dm_req ? data_q[rd_ptr_q] : 32'h0;
  assign dm_wstrb = dm_req ? strb_q[rd_ptr_q] : 4'b0000;

`ifdef STORE_MISALIGN_CHK_EN
  assign misalign = misalign_q;
`else
  // Without the checker the pulse register has no consumer and is optimised out.
  logic unused_mis;
  assign unused_mis = misalign_q;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer. The stimulus process predicts each
// accepted store from the store-width rules and pushes the expected memory
// write into a queue; the monitor checks the DUT on every falling edge and pops
// an entry whenever it sees a completed dm_req/dm_ack handshake.
module tb_store_buffer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [2:0]    funct3;
  logic          st_ready;
  logic          dm_req;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_wstrb;
  logic          dm_ack;
  logic          sb_empty;
  logic [CW-1:0] sb_count;
`ifdef STORE_MISALIGN_CHK_EN
  logic          misalign;
`endif

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .funct3   (funct3),
    .st_ready (st_ready),
    .dm_req   (dm_req),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wstrb (dm_wstrb),
`ifdef STORE_MISALIGN_CHK_EN
    .misalign (misalign),
`endif
    .dm_ack   (dm_ack),
    .sb_empty (sb_empty),
    .sb_count (sb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   pend     = 1'b0;
  ent_t pend_e;
  bit   pend_mis = 1'b0;
  bit   mis_exp  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference rules for one accepted store: returns 1 if it is queued.
  function automatic bit model(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f, output ent_t e, output bit mis);
    int unsigned lane;
    lane   = a % 4;
    e.addr = a - lane;
    e.data = 32'h0;
    e.strb = 4'h0;
    mis    = 1'b0;
    case (f)
      3'd0: begin
        e.strb = 4'(1 << lane);
        e.data = d[7:0] * 32'h0101_0101;
      end
      3'd1: begin
        e.strb = (lane >= 2) ? 4'd12 : 4'd3;
        e.data = d[15:0] * 32'h0001_0001;
`ifdef STORE_MISALIGN_CHK_EN
        mis = (a % 2) != 0;
`endif
      end
      3'd2: begin
        e.strb = 4'd15;
        e.data = d;
`ifdef STORE_MISALIGN_CHK_EN
        mis = lane != 0;
`endif
      end
      default: return 1'b0;
    endcase
    return !mis;
  endfunction

  // One clock of stimulus: commit last cycle's prediction at the edge, then
  // drive new inputs 1 time unit later.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit ack);
    @(posedge clk);
    if (pend) exp_q.push_back(pend_e);
    mis_exp  = pend_mis;
    pend     = 1'b0;
    pend_mis = 1'b0;
    #1;
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    funct3   = f;
    dm_ack   = ack;
    if (v && (exp_q.size() < DEPTH)) begin
      ent_t e;
      bit   m;
      pend     = model(a, d, f, e, m);
      pend_e   = e;
      pend_mis = m;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    if (pend) exp_q.push_back(pend_e);
    pend     = 1'b0;
    pend_mis = 1'b0;
    #1;
    st_valid = 1'b0;
    dm_ack   = 1'b1;
    rst      = 1'b0;
    #1;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_sb_count", sb_count, 0);
    chk("rst_sb_empty", sb_empty, 1);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_dm_wstrb", dm_wstrb, 0);
    exp_q.delete();
    mis_exp = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  // Monitor: compare against the scoreboard every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("st_ready", st_ready, exp_q.size() < DEPTH);
        chk("sb_count", sb_count, exp_q.size());
        chk("sb_empty", sb_empty, exp_q.size() == 0);
        chk("dm_req", dm_req, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("dm_addr", dm_addr, exp_q[0].addr);
          chk("dm_wdata", dm_wdata, exp_q[0].data);
          chk("dm_wstrb", dm_wstrb, exp_q[0].strb);
          if (dm_ack) void'(exp_q.pop_front());
        end else begin
          chk("idle_dm_addr", dm_addr, 0);
          chk("idle_dm_wdata", dm_wdata, 0);
          chk("idle_dm_wstrb", dm_wstrb, 0);
        end
`ifdef STORE_MISALIGN_CHK_EN
        chk("misalign", misalign, mis_exp);
`endif
      end
    end
  end

  initial begin
    bit          v;
    bit          ack;
    logic [2:0]  f;
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    funct3   = 3'b000;
    dm_ack   = 1'b0;

    #2;
    chk("init_st_ready", st_ready, 1);
    chk("init_sb_empty", sb_empty, 1);
    chk("init_sb_count", sb_count, 0);
    chk("init_dm_req", dm_req, 0);
    chk("init_dm_addr", dm_addr, 0);
`ifdef STORE_MISALIGN_CHK_EN
    chk("init_misalign", misalign, 0);
`endif
    #10 rst = 1'b1;

    // SB to 0x1003, ack held high
    cycle(1, 32'h1003, 32'hAABB_CCDD, 3'b000, 1);
    repeat (3) cycle(0, 0, 0, 3'b000, 1);

    // SH to 0x2002, three stalled request cycles then ack
    cycle(1, 32'h2002, 32'h1234_5678, 3'b001, 0);
    repeat (3) cycle(0, 0, 0, 3'b000, 0);
    cycle(0, 0, 0, 3'b000, 1);
    cycle(0, 0, 0, 3'b000, 1);

    // Fill with three SWs, then push while draining the full queue
    cycle(1, 32'h4000, 32'h1111_1111, 3'b010, 0);
    cycle(1, 32'h4004, 32'h2222_2222, 3'b010, 0);
    cycle(1, 32'h4008, 32'h3333_3333, 3'b010, 0);
    cycle(1, 32'h400C, 32'h4444_4444, 3'b010, 1);
    cycle(1, 32'h400C, 32'h4444_4444, 3'b010, 1);
    repeat (4) cycle(0, 0, 0, 3'b000, 1);

    // Unsupported funct3 is swallowed
    cycle(1, 32'h6000, 32'h5555_5555, 3'b111, 1);
    cycle(1, 32'h6004, 32'h6666_6666, 3'b011, 1);
    repeat (2) cycle(0, 0, 0, 3'b000, 1);

    // Reset with two entries queued
    cycle(1, 32'h5000, 32'hDEAD_0001, 3'b010, 0);
    cycle(1, 32'h5004, 32'hDEAD_0002, 3'b010, 0);
    cycle(0, 0, 0, 3'b000, 0);
    do_reset();
    repeat (3) cycle(0, 0, 0, 3'b000, 1);

    // Misaligned SW
    cycle(1, 32'h3001, 32'hCAFE_BABE, 3'b010, 1);
    repeat (3) cycle(0, 0, 0, 3'b000, 1);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      ack = ($urandom_range(0, 9) < 5);
      f   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      cycle(v, $urandom, $urandom, f, ack);
      if (i == 300) do_reset();
    end
    repeat (6) cycle(0, 0, 0, 3'b000, 1);
    chk("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of queue entries; legal values are powers of 2, at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port st_valid, input, 1 bit: a store request is presented this cycle.
REQ-005 The block SHALL have port st_addr, input, 32 bits: the store byte address.
REQ-006 The block SHALL have port st_data, input, 32 bits: the raw rs2 value.
REQ-007 The block SHALL have port funct3, input, 3 bits: 000 = SB, 001 = SH, 010 = SW.
REQ-008 The block SHALL have port st_ready, output, 1 bit: the queue can accept a request.
REQ-009 The block SHALL have port dm_req, output, 1 bit: a data-memory write request is pending.
REQ-010 The block SHALL have port dm_addr, output, 32 bits: the word-aligned write address, with [1:0] = 00.
REQ-011 The block SHALL have port dm_wdata, output, 32 bits: lane-replicated write data.
REQ-012 The block SHALL have port dm_wstrb, output, 4 bits: active-high byte write enables; bit i covers dm_wdata[8i+7:8i].
REQ-013 The block SHALL have port dm_ack, input, 1 bit: memory accepted the current request.
REQ-014 The block SHALL have port sb_empty, output, 1 bit: the queue holds no entries.
REQ-015 The block SHALL have port sb_count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-016 The block SHALL have port misalign, output, 1 bit: misaligned-store flag; this port exists only when the macro in REQ-034 is defined.

Function
REQ-017 A request SHALL be accepted on a rising edge where st_valid=1 and st_ready=1.
REQ-018 st_ready SHALL equal (sb_count < DEPTH), depending only on registered occupancy; it SHALL never depend combinationally on dm_ack.
REQ-019 For SB, an accepted request SHALL enqueue wstrb = 0001 << st_addr[1:0] and wdata = {4{st_data[7:0]}}.
REQ-020 For SH, an accepted request SHALL enqueue wstrb = st_addr[1] ? 1100 : 0011 and wdata = {2{st_data[15:0]}}.
REQ-021 For SW, an accepted request SHALL enqueue wstrb = 1111 and wdata = st_data.
REQ-022 Every enqueued entry SHALL store address {st_addr[31:2], 2'b00}.
REQ-023 A request with any other funct3 value SHALL be accepted and discarded, with no enqueue and no occupancy change.
REQ-024 When sb_count > 0, dm_req SHALL be 1 and dm_addr, dm_wdata and dm_wstrb SHALL show the head entry; they SHALL stay stable until the cycle in which dm_ack=1.
REQ-025 A rising edge with dm_req=1 and dm_ack=1 SHALL dequeue the head entry.
REQ-026 When sb_count = 0, dm_req SHALL be 0, dm_addr, dm_wdata and dm_wstrb SHALL be 0, and dm_ack SHALL be ignored.
REQ-027 There SHALL be no bypass: a request accepted at edge N into an empty queue first raises dm_req after edge N, giving a minimum latency of 1 cycle.
REQ-028 Simultaneous enqueue and dequeue on the same edge SHALL leave sb_count unchanged and move both pointers; when full, this is impossible because st_ready=0.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 sb_count SHALL never exceed DEPTH and never underflow.
REQ-031 Entries SHALL be issued strictly in acceptance order.
REQ-032 sb_empty SHALL equal (sb_count == 0).

Reset
REQ-033 When rst=0, asynchronously: pointers and sb_count SHALL go to 0, all stored entries SHALL be invalidated, dm_req, dm_addr, dm_wdata, dm_wstrb and misalign SHALL go to 0, st_ready SHALL be 1 and sb_empty SHALL be 1. Reset asserted mid-transaction SHALL drop all queued and pending stores without completing them.

Configuration
REQ-034 With STORE_MISALIGN_CHK_EN defined, an accepted SH with st_addr[0]=1, or an accepted SW with st_addr[1:0]!=00, SHALL NOT be enqueued, and misalign SHALL pulse high for exactly one cycle after the accepting edge. Without the macro, the misalign port SHALL be absent, SH SHALL ignore st_addr[0], SW SHALL ignore st_addr[1:0], and all such requests SHALL be enqueued.

Verification
REQ-035 SB to 0x1003 with st_data 0xAABBCCDD, dm_ack held 1 -> next cycle dm_req=1, dm_addr=0x1000, dm_wstrb=1000, dm_wdata=0xDDDDDDDD; sb_empty=1 one cycle later.
REQ-036 SH to 0x2002 with st_data 0x12345678, dm_ack=0 for 3 cycles -> dm_wstrb=1100 and dm_wdata=0x56785678, held stable for all 4 request cycles; dequeued on the ack edge.
REQ-037 DEPTH=2, three back-to-back SW requests, dm_ack=0 -> st_ready=0 after the second, the third is not accepted, sb_count=2; on ack, order is preserved.
REQ-038 Full queue, then st_valid=1 and dm_ack=1 together -> st_ready is still 0 that cycle, count drops to 1, and the new store is accepted on the following edge.
REQ-039 rst pulsed low while 2 entries are queued -> dm_req=0 and sb_count=0 immediately; no write is issued after release.
REQ-040 With STORE_MISALIGN_CHK_EN, SW to 0x3001 -> misalign=1 for one cycle, dm_req stays 0; without the macro -> enqueued to 0x3000 with wstrb 1111.
